// File: rtl/ps2_key_tx_pkg.sv
// rtl/ps2_key_tx_pkg.sv - shared PS/2 link constants, FSM encodings and frame builder
package ps2_key_tx_pkg;

   localparam logic [7:0] BRK_CODE  = 8'hF0;
   localparam int         FRAME_LEN = 11;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CHK_BUS = 3'd1;
   localparam logic [2:0] S_BIT_HI  = 3'd2;
   localparam logic [2:0] S_BIT_LO  = 3'd3;
   localparam logic [2:0] S_GAP     = 3'd4;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Bit 0 goes out first: start, data LSB first, odd parity, stop.
   function automatic logic [FRAME_LEN-1:0] make_frame(input logic [7:0] data);
      return {1'b1, ~^data, data, 1'b0};
   endfunction

endpackage

// File: rtl/ps2_key_tx_timer.sv
// rtl/ps2_key_tx_timer.sv - loadable down-counter shared by half-period, gap and idle-check timing
module ps2_key_tx_timer #(
   parameter int W = 13
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic [W-1:0] count_o,
   output logic         done_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign count_o = count_q;
   assign done_o  = (count_q == '0);

endmodule

// File: rtl/ps2_key_tx.sv
// rtl/ps2_key_tx.sv - device-side PS/2 keyboard transmitter (make / F0-prefixed break sequences)
module ps2_key_tx
   import ps2_key_tx_pkg::*;
#(
   parameter int CLK_HALF = 4000,
   parameter int GAP      = 5000,
   parameter int IDLE_CHK = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] key_code,
   input  logic       key_brk,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic       ps2c_in,
   output logic       ps2c_drv,
   output logic       ps2d_drv,
   output logic       busy,
   output logic       tx_done
);

   localparam int TW = $clog2(max3(CLK_HALF, GAP, IDLE_CHK) + 1);
   localparam logic [TW-1:0] HALF_TC = TW'(CLK_HALF - 1);
   localparam logic [TW-1:0] GAP_TC  = TW'(GAP - 1);
   localparam logic [TW-1:0] CHK_TC  = TW'(IDLE_CHK - 1);
   // Our own clock release needs two cycles to reach the synchroniser output.
   localparam logic [TW-1:0] INH_LIMIT = TW'(CLK_HALF - 3);
   localparam logic [3:0]    LAST_BIT  = 4'(FRAME_LEN - 1);

   logic [2:0]           state_q, state_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [FRAME_LEN-1:0] frame_q, frame_d;
   logic [7:0]           byte0_q, byte0_d, byte1_q, byte1_d;
   logic                 two_q, two_d, sec_q, sec_d;
   logic [1:0]           sync_q;
   logic                 ps2c_drv_q, ps2c_drv_d, ps2d_drv_q, ps2d_drv_d;
   logic                 busy_q, tx_done_q, tx_done_d;
   logic                 tmr_load, tmr_done;
   logic [TW-1:0]        tmr_val, tmr_count;
   logic                 ps2c_s;
   logic [7:0]           cur_byte;

   assign ps2c_s   = sync_q[1];
   assign cur_byte = sec_q ? byte1_q : byte0_q;

   ps2_key_tx_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .count_o    (tmr_count),
      .done_o     (tmr_done)
   );

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      frame_d   = frame_q;
      byte0_d   = byte0_q;
      byte1_d   = byte1_q;
      two_d     = two_q;
      sec_d     = sec_q;
      tx_done_d = 1'b0;
      tmr_load  = 1'b0;
      tmr_val   = HALF_TC;
      case (state_q)
         S_IDLE: begin
            if (key_valid) begin
               byte0_d  = key_brk ? BRK_CODE : key_code;
               byte1_d  = key_code;
               two_d    = key_brk;
               sec_d    = 1'b0;
               state_d  = S_CHK_BUS;
               tmr_load = 1'b1;
               tmr_val  = CHK_TC;
            end
         end
         S_CHK_BUS: begin
            if (!ps2c_s) begin
               tmr_load = 1'b1;
               tmr_val  = CHK_TC;
            end else if (tmr_done) begin
               frame_d   = make_frame(cur_byte);
               bit_cnt_d = 4'd0;
               state_d   = S_BIT_HI;
               tmr_load  = 1'b1;
            end
         end
         S_BIT_HI: begin
            // Host inhibit: drop the frame and resend the current byte once the bus frees up.
            if (!ps2c_s && bit_cnt_q != LAST_BIT && tmr_count <= INH_LIMIT) begin
               bit_cnt_d = 4'd0;
               state_d   = S_CHK_BUS;
               tmr_load  = 1'b1;
               tmr_val   = CHK_TC;
            end else if (tmr_done) begin
               state_d  = S_BIT_LO;
               tmr_load = 1'b1;
            end
         end
         S_BIT_LO: begin
            if (tmr_done) begin
               tmr_load = 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = S_GAP;
                  tmr_val = GAP_TC;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  frame_d   = frame_q >> 1;
                  state_d   = S_BIT_HI;
               end
            end
         end
         S_GAP: begin
            if (tmr_done) begin
               if (two_q && !sec_q) begin
                  sec_d    = 1'b1;
                  state_d  = S_CHK_BUS;
                  tmr_load = 1'b1;
                  tmr_val  = CHK_TC;
               end else begin
                  state_d   = S_IDLE;
                  tx_done_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      ps2c_drv_d = (state_d == S_BIT_LO);
      ps2d_drv_d = ((state_d == S_BIT_HI) || (state_d == S_BIT_LO)) && !frame_d[0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= 4'd0;
         frame_q    <= '0;
         byte0_q    <= 8'd0;
         byte1_q    <= 8'd0;
         two_q      <= 1'b0;
         sec_q      <= 1'b0;
         sync_q     <= 2'b11;
         ps2c_drv_q <= 1'b0;
         ps2d_drv_q <= 1'b0;
         busy_q     <= 1'b0;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         frame_q    <= frame_d;
         byte0_q    <= byte0_d;
         byte1_q    <= byte1_d;
         two_q      <= two_d;
         sec_q      <= sec_d;
         sync_q     <= {sync_q[0], ps2c_in};
         ps2c_drv_q <= ps2c_drv_d;
         ps2d_drv_q <= ps2d_drv_d;
         busy_q     <= (state_d != S_IDLE);
         tx_done_q  <= tx_done_d;
      end
   end

   assign key_ready = (state_q == S_IDLE);
   assign ps2c_drv  = ps2c_drv_q;
   assign ps2d_drv  = ps2d_drv_q;
   assign busy      = busy_q;
   assign tx_done   = tx_done_q;

endmodule
